// File: rtl/z_word_collector.sv
// z_word_collector
//   Collects the serial z output of the minterm circuit into WIDTH-bit words.
//   The first received bit lands in the MSB. Each word carries a ones-count and
//   a valid-bit length. Words leave through a valid/ready output register.
//   A flush request emits the current partial word, zero-padded at the bottom.
//
// State table
//   state      | meaning
//   COLLECT    | accepting bits, emitting full or flushed words
//   FLUSH_WAIT | partial word frozen, waiting for the output slot to free up
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   z_in, z_valid       serial bit and its qualifier
//   z_ready             collector accepts z_in this cycle
//   flush               request to emit the current partial word
//   word_out            packed word (first bit at MSB)
//   ones_out, word_len  ones count and number of valid bits in word_out
//   word_valid          output register holds an unconsumed word
//   word_ready          consumer takes the word this cycle
module z_word_collector #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_in,
  input  logic             z_valid,
  output logic             z_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic [CW-1:0]    ones_out,
  output logic [CW-1:0]    word_len,
  output logic             word_valid,
  input  logic             word_ready
);

  typedef enum logic {COLLECT, FLUSH_WAIT} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_new;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_new;
  logic [CW-1:0]    ones_q, ones_d, ones_new;

  logic [WIDTH-1:0] word_q, word_d, ld_word;
  logic [CW-1:0]    wones_q, wones_d, ld_ones;
  logic [CW-1:0]    wlen_q, wlen_d, ld_len;
  logic             wvalid_q, wvalid_d;

  logic slot_free, acc, load;

  // A consume in the same cycle frees the slot for a new load.
  assign slot_free = !wvalid_q || word_ready;

  // Only the bit that would complete a word needs the slot; earlier bits
  // are always accepted.
  assign z_ready = (state_q == COLLECT) && ((cnt_q != LAST) || slot_free);
  assign acc     = z_valid && z_ready;

  always_comb begin
    sr_new = sr_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (acc && (cnt_q == CW'(WIDTH - 1 - i))) sr_new[i] = z_in;
    end
    cnt_new  = cnt_q + {{(CW-1){1'b0}}, acc};
    ones_new = ones_q + {{(CW-1){1'b0}}, acc && z_in};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    load    = 1'b0;
    ld_word = sr_new;
    ld_ones = ones_new;
    ld_len  = cnt_new;
    case (state_q)
      COLLECT: begin
        if (acc && (cnt_q == LAST)) begin
          // Full word wins over a coincident flush.
          load   = 1'b1;
          sr_d   = '0;
          cnt_d  = '0;
          ones_d = '0;
        end else if (flush && (cnt_new != '0)) begin
          if (slot_free) begin
            load   = 1'b1;
            sr_d   = '0;
            cnt_d  = '0;
            ones_d = '0;
          end else begin
            state_d = FLUSH_WAIT;
            sr_d    = sr_new;
            cnt_d   = cnt_new;
            ones_d  = ones_new;
          end
        end else begin
          sr_d   = sr_new;
          cnt_d  = cnt_new;
          ones_d = ones_new;
        end
      end
      FLUSH_WAIT: begin
        ld_word = sr_q;
        ld_ones = ones_q;
        ld_len  = cnt_q;
        if (slot_free) begin
          load    = 1'b1;
          state_d = COLLECT;
          sr_d    = '0;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    word_d   = word_q;
    wones_d  = wones_q;
    wlen_d   = wlen_q;
    wvalid_d = wvalid_q;
    if (load) begin
      word_d   = ld_word;
      wones_d  = ld_ones;
      wlen_d   = ld_len;
      wvalid_d = 1'b1;
    end else if (wvalid_q && word_ready) begin
      wvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      sr_q     <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      word_q   <= '0;
      wones_q  <= '0;
      wlen_q   <= '0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      word_q   <= word_d;
      wones_q  <= wones_d;
      wlen_q   <= wlen_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign word_out   = word_q;
  assign ones_out   = wones_q;
  assign word_len   = wlen_q;
  assign word_valid = wvalid_q;

endmodule

// File: tb/tb_z_word_collector.sv
module tb_z_word_collector;

  localparam int WIDTH = 8;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             z_in, z_valid, flush, word_ready;
  logic             z_ready, word_valid;
  logic [WIDTH-1:0] word_out;
  logic [CW-1:0]    ones_out, word_len;

  int checks = 0;
  int errors = 0;

  z_word_collector #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .z_in(z_in), .z_valid(z_valid), .z_ready(z_ready), .flush(flush),
    .word_out(word_out), .ones_out(ones_out), .word_len(word_len),
    .word_valid(word_valid), .word_ready(word_ready)
  );

  always #5 clk = ~clk;

  // fmode: 0 no flush, 1 flush with the last bit, 2 flush in a separate cycle
  typedef struct {
    logic [15:0] bits;
    int          n;
    int          fmode;
    bit          exp_emit;
    logic [7:0]  exp_word;
    logic [4:0]  exp_ones;
    logic [4:0]  exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fl);
    z_in    = b;
    z_valid = 1'b1;
    flush   = fl;
    chk("z_ready_on_send", {31'b0, z_ready}, 32'd1);
    tick();
    z_valid = 1'b0;
    flush   = 1'b0;
    z_in    = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) send_bit(bits[k], 1'b0);
  endtask

  task automatic chk_word(input string name, input logic [7:0] w, input logic [4:0] o,
                          input logic [4:0] l);
    chk({name, "_valid"}, {31'b0, word_valid}, 32'd1);
    chk({name, "_word"}, {24'b0, word_out}, {24'b0, w});
    chk({name, "_ones"}, {27'b0, ones_out}, {27'b0, o});
    chk({name, "_len"}, {27'b0, word_len}, {27'b0, l});
  endtask

  initial begin
    //          bits     n  fm emit word   ones len
    vecs[0] = '{16'h0062, 8, 0, 1'b1, 8'h62, 5'd3, 5'd8};
    vecs[1] = '{16'h0006, 3, 1, 1'b1, 8'hC0, 5'd2, 5'd3};
    vecs[2] = '{16'h0000, 0, 2, 1'b0, 8'h00, 5'd0, 5'd0};
    vecs[3] = '{16'h0001, 8, 1, 1'b1, 8'h01, 5'd1, 5'd8};
    vecs[4] = '{16'h00FF, 8, 0, 1'b1, 8'hFF, 5'd8, 5'd8};
    vecs[5] = '{16'h0001, 1, 1, 1'b1, 8'h80, 5'd1, 5'd1};
    vecs[6] = '{16'h0055, 7, 1, 1'b1, 8'hAA, 5'd4, 5'd7};
    vecs[7] = '{16'h0003, 2, 2, 1'b1, 8'hC0, 5'd2, 5'd2};

    rst_n = 1'b0; z_in = 1'b0; z_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_word", {24'b0, word_out}, 32'd0);
    chk("rst_ones", {27'b0, ones_out}, 32'd0);
    chk("rst_len", {27'b0, word_len}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("z_ready_after_rst", {31'b0, z_ready}, 32'd1);

    // Table: word-level vectors with the consumer always ready
    for (int v = 0; v < 8; v++) begin
      for (int k = vecs[v].n - 1; k >= 0; k--)
        send_bit(vecs[v].bits[k], (vecs[v].fmode == 1) && (k == 0));
      if (vecs[v].fmode == 2) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      chk($sformatf("vec%0d_emit", v), {31'b0, word_valid}, {31'b0, vecs[v].exp_emit});
      if (vecs[v].exp_emit) begin
        chk($sformatf("vec%0d_word", v), {24'b0, word_out}, {24'b0, vecs[v].exp_word});
        chk($sformatf("vec%0d_ones", v), {27'b0, ones_out}, {27'b0, vecs[v].exp_ones});
        chk($sformatf("vec%0d_len", v), {27'b0, word_len}, {27'b0, vecs[v].exp_len});
      end
      tick();
      chk($sformatf("vec%0d_drained", v), {31'b0, word_valid}, 32'd0);
    end

    // Back-pressure: second word stalls on its last bit until the slot drains
    word_ready = 1'b0;
    send_bits(16'h00FF, 8);
    chk_word("bp_first", 8'hFF, 5'd8, 5'd8);
    send_bits(16'h0055, 7);
    z_in = 1'b0; z_valid = 1'b1;
    #1;
    chk("bp_stall", {31'b0, z_ready}, 32'd0);
    tick();
    tick();
    chk_word("bp_hold", 8'hFF, 5'd8, 5'd8);
    chk("bp_still_stalled", {31'b0, z_ready}, 32'd0);
    word_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, z_ready}, 32'd1);
    tick();
    z_valid = 1'b0;
    chk_word("bp_second", 8'hAA, 5'd4, 5'd8);
    tick();
    chk("bp_drained", {31'b0, word_valid}, 32'd0);

    // Flush while the slot is occupied -> FLUSH_WAIT
    word_ready = 1'b0;
    send_bits(16'h000F, 8);
    chk_word("fw_blocker", 8'h0F, 5'd4, 5'd8);
    send_bits(16'h0005, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fw_zready_low", {31'b0, z_ready}, 32'd0);
    flush = 1'b1; z_valid = 1'b1; z_in = 1'b1;
    tick();
    flush = 1'b0; z_valid = 1'b0; z_in = 1'b0;
    chk_word("fw_hold", 8'h0F, 5'd4, 5'd8);
    chk("fw_zready_still_low", {31'b0, z_ready}, 32'd0);
    word_ready = 1'b1;
    tick();
    chk_word("fw_partial", 8'hA0, 5'd2, 5'd3);
    chk("fw_back_collect", {31'b0, z_ready}, 32'd1);
    tick();
    chk("fw_drained", {31'b0, word_valid}, 32'd0);

    // Asynchronous reset mid-word with a pending output word
    word_ready = 1'b0;
    send_bits(16'h0033, 8);
    send_bits(16'h001D, 5);
    chk("ar_pending", {31'b0, word_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, word_valid}, 32'd0);
    chk("ar_word", {24'b0, word_out}, 32'd0);
    chk("ar_ones", {27'b0, ones_out}, 32'd0);
    chk("ar_len", {27'b0, word_len}, 32'd0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    word_ready = 1'b1;
    tick();
    send_bits(16'h005A, 8);
    chk_word("ar_fresh", 8'h5A, 5'd4, 5'd8);
    tick();
    chk("ar_drained", {31'b0, word_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z_word_collector.md
Name: z_word_collector

Overview:
- Downstream stage of the 3-input minterm circuit: consumes its serial z output one bit per accepted cycle.
- Packs the bits into WIDTH-bit words and reports a ones-count and a valid-bit length with each word.
- Hands words to a consumer through a valid/ready output register.
- A flush request emits a partial, zero-padded word.

Parameters:
WIDTH, 8, bits per word; legal 2..16
CW, 5, width of ones_out, word_len and the internal bit counter; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
z_in  input  1  serial data bit from the minterm circuit
z_valid  input  1  z_in is meaningful this cycle
z_ready  output  1  collector can accept z_in this cycle
flush  input  1  single-cycle request to emit the current partial word
word_out  output  WIDTH  packed word; first received bit at word_out[WIDTH-1]
ones_out  output  CW  number of 1 bits in word_out
word_len  output  CW  number of received bits in word_out, 1..WIDTH
word_valid  output  1  output register holds an unconsumed word
word_ready  input  1  consumer takes the word this cycle

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
  - In reset: word_out=0, ones_out=0, word_len=0, word_valid=0, bit_cnt=0, shift register=0, state=COLLECT.
  - After rst_n rises, z_ready=1.
- Accept: bit taken when z_valid && z_ready.
  - Written at sr[WIDTH-1-bit_cnt].
  - bit_cnt increments; the running ones count increments if z_in=1.
- Output handshake:
  - A word is consumed when word_valid && word_ready.
  - slot_free = !word_valid || word_ready. A same-cycle drain frees the slot.
  - word_out, ones_out and word_len hold stable while word_valid=1 && word_ready=0.
  - word_valid clears on consume unless a new word loads that same edge.
- States:
  - COLLECT: z_ready = (bit_cnt != WIDTH-1) || slot_free.
  - FLUSH_WAIT: z_ready=0. Waits for slot_free.
- Word complete: an accepted bit with bit_cnt==WIDTH-1 causes the following at that edge:
  - Full word, including the new bit, loads into the output register.
  - word_len=WIDTH; ones_out = running count including the new bit; word_valid=1.
  - sr, bit_cnt and the running count clear.
  - Latency from last bit accepted to word_valid is 1 clock.
- Stall: when bit_cnt==WIDTH-1 and the slot is not free, z_ready=0. No bit is ever dropped.
- Flush in COLLECT with bit_cnt>0, or with a bit accepted that cycle:
  - The bit accepted in the flush cycle is included.
  - If the slot is free: the partial word loads at that edge. Unused low bits are 0; word_len = bits received.
  - If the slot is not free: go to FLUSH_WAIT, holding the partial word.
  - In FLUSH_WAIT: when slot_free, load the word and return to COLLECT at that edge.
- Flush with bit_cnt==0 and no bit accepted: ignored; no word is emitted.
- Flush on the same cycle a word completes: only the full word is emitted; the flush has no further effect.
- flush asserted in FLUSH_WAIT: ignored.
- Reset mid-word or mid-flush: the partial word and any pending output are discarded.
- ones_out never exceeds word_len. word_len is never 0 while word_valid=1.

Test Plan:
- Reset with word_ready=1, then z sequence 0,1,1,0,0,0,1,0 (minterms 1,2,6 over x=0..7) with z_valid=1 -> one clock after the 8th bit: word_valid=1, word_out=0x62, ones_out=3, word_len=8.
- word_ready=0, send 8 bits of 1 then 8 bits 1,0,1,0,1,0,1,0 (second word is the back-pressure word) -> first word 0xFF, ones 8 held stable.
  - During the second word, z_ready drops at bit_cnt=7 of that word.
  - Raise word_ready -> 0xFF consumed; 0xAA (ones 4) loads the same edge; no bit lost.
- Bits 1,1,0 then flush (slot free) -> word_out=0xC0, ones_out=2, word_len=3, word_valid next clock.
- Bits 1,0,1 with word_valid=1 and word_ready=0, pulse flush -> FLUSH_WAIT, z_ready=0.
  - Release word_ready -> word_out=0xA0, word_len=3, ones_out=2; state returns to COLLECT, z_ready=1.
- Flush with bit_cnt=0 -> no word emitted.
  - Flush on the same cycle as the 8th bit of 0x01 -> exactly one word, 0x01 with word_len=8; no extra empty word.
- Assert rst_n=0 after 5 bits while word_valid=1 -> all outputs 0 immediately (asynchronous).
  - After release, 8 fresh bits produce a correct word with no residue from the partial word.
